// File: rtl/mult_div_unit.sv
// mult_div_unit: multicycle MULT/MULTU/DIV/DIVU coprocessor owning the HI/LO pair.
// Works on operand magnitudes, one bit per clock (shift-add multiply, restoring
// divide), then applies the sign correction in a single FIX cycle before the
// result lands in HI/LO. busy holds the control FSM in its wait state.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             hi_write,
    input  logic             lo_write,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] COUNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] COUNT_LAST = CW'(1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MUL  = 3'd1;
    localparam logic [2:0] S_DIV  = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    // op[1] selects divide, op[0] selects unsigned.
    logic [2:0]         state;
    logic [1:0]         op_r;
    logic               sa;
    logic               sb;
    logic               dz_r;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   opnd;      // multiplicand (MUL) or divisor (DIV) magnitude
    logic [2*WIDTH-1:0] acc;       // MUL: {partial product, multiplier}; DIV: {remainder, quotient}

    logic               in_signed;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] div_next;
    logic               fix_signed;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Operand magnitudes, one iteration step of each algorithm, and sign fix-up.
    always_comb begin
        // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
        in_signed  = ~op[0];
        a_mag      = (in_signed && A[WIDTH-1]) ? -A : A;
        b_mag      = (in_signed && B[WIDTH-1]) ? -B : B;

        mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_next   = {mul_sum, acc[WIDTH-1:1]};

        div_trial  = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
        div_next   = div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                      : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

        fix_signed = ~op_r[0];
        prod_fix   = (fix_signed && (sa ^ sb)) ? -acc : acc;
        quo_fix    = (fix_signed && (sa ^ sb)) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix    = (fix_signed && sa) ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    // Sequencer and iteration datapath: launch from IDLE, iterate, fix, pulse done.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state <= S_IDLE;
            op_r  <= '0;
            sa    <= 1'b0;
            sb    <= 1'b0;
            dz_r  <= 1'b0;
            count <= '0;
            opnd  <= '0;
            acc   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_r  <= op;
                        sa    <= A[WIDTH-1];
                        sb    <= B[WIDTH-1];
                        count <= COUNT_INIT;
                        dz_r  <= 1'b0;
                        if (!op[1]) begin
                            opnd  <= a_mag;
                            acc   <= {{WIDTH{1'b0}}, b_mag};
                            state <= S_MUL;
                        end else if (B == '0) begin
                            dz_r  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            opnd  <= b_mag;
                            acc   <= {{WIDTH{1'b0}}, a_mag};
                            state <= S_DIV;
                        end
                    end
                end
                S_MUL: begin
                    acc   <= mul_next;
                    count <= count - 1'b1;
                    if (count == COUNT_LAST) state <= S_FIX;
                end
                S_DIV: begin
                    acc   <= div_next;
                    count <= count - 1'b1;
                    if (count == COUNT_LAST) state <= S_FIX;
                end
                S_FIX: begin
                    state <= S_DONE;
                end
                S_DONE: begin
                    dz_r  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // HI/LO: written with the fixed-up result at FIX, or from A by MTHI/MTLO in IDLE.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            HI <= '0;
            LO <= '0;
        end else if (state == S_FIX) begin
            if (op_r[1]) begin
                HI <= rem_fix;
                LO <= quo_fix;
            end else begin
                HI <= prod_fix[2*WIDTH-1:WIDTH];
                LO <= prod_fix[WIDTH-1:0];
            end
        end else if (state == S_IDLE && !start) begin
            if (hi_write) HI <= A;
            if (lo_write) LO <= A;
        end
    end

    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);
    assign div_zero = done & dz_r;

endmodule
